// File: rtl/learn_score_keeper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | learn_score_keeper_pkg                                               |
// | Shared learn-mode state encodings and response-grade thresholds.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package learn_score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEARN  = 2'd1,
    ST_FINISH = 2'd2
  } learn_state_e;

  localparam logic [3:0] c_grade_t1  = 4'd5;
  localparam logic [3:0] c_grade_t2  = 4'd10;
  localparam logic [3:0] c_grade_t3  = 4'd15;
  localparam logic [3:0] c_ticks_max = 4'd15;

  // Maps elapsed 100 ms ticks onto the 1-4 response grade.
  function automatic logic [2:0] grade_of(input logic [3:0] ticks);
    if (ticks < c_grade_t1)      grade_of = 3'd1;
    else if (ticks < c_grade_t2) grade_of = 3'd2;
    else if (ticks < c_grade_t3) grade_of = 3'd3;
    else                         grade_of = 3'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/learn_score_keeper_bcd2_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd2_counter                                                         |
// | Two-digit BCD up-counter, synchronous clear, saturating at 99.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bcd2_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (clear) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (inc && !(r_tens == 4'd9 && r_ones == 4'd9)) begin
      if (r_ones == 4'd9) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;

endmodule
`default_nettype wire

// File: rtl/learn_score_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | learn_score_keeper                                                   |
// | Tracks score, response grade and note count for the learn page.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module learn_score_keeper
  import learn_score_keeper_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] learn_state,
  input  logic       note_valid,
  input  logic       note_correct,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [2:0] interval,
  output logic [5:0] note_cnt
);

  localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);

  logic [1:0]           r_prev_state;
  logic [c_presc_w-1:0] r_presc;
  logic [3:0]           r_ticks;
  logic [2:0]           r_interval;
  logic [5:0]           r_note_cnt;

  logic       w_in_learn;
  logic       w_in_finish;
  logic       w_entry;
  logic       w_run;
  logic       w_clear;
  logic       w_wrap;
  logic [3:0] w_ticks_now;
  logic       w_score_inc;

  assign w_in_learn  = (learn_state == ST_LEARN);
  assign w_in_finish = (learn_state == ST_FINISH);
  assign w_entry     = w_in_learn && (r_prev_state != ST_LEARN);
  assign w_run       = w_in_learn && !w_entry;
  assign w_clear     = w_entry || (!w_in_learn && !w_in_finish);
  assign w_wrap      = (r_presc == c_presc_max);

  // A tick completing on this very edge counts toward the grade.
  assign w_ticks_now = (w_wrap && r_ticks != c_ticks_max) ? r_ticks + 4'd1 : r_ticks;
  assign w_score_inc = w_run && note_valid && note_correct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_state <= ST_IDLE;
    end else begin
      r_prev_state <= learn_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_ticks    <= 4'd0;
      r_interval <= 3'd0;
      r_note_cnt <= 6'd0;
    end else if (w_clear) begin
      r_presc    <= '0;
      r_ticks    <= 4'd0;
      r_interval <= 3'd0;
      r_note_cnt <= 6'd0;
    end else if (w_run) begin
      if (note_valid) begin
        r_presc    <= '0;
        r_ticks    <= 4'd0;
        r_interval <= grade_of(w_ticks_now);
        if (r_note_cnt != 6'd63) begin
          r_note_cnt <= r_note_cnt + 6'd1;
        end
      end else begin
        r_presc <= w_wrap ? '0 : r_presc + c_presc_w'(1);
        r_ticks <= w_ticks_now;
      end
    end
  end

  bcd2_counter u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .inc   (w_score_inc),
    .tens  (digit1),
    .ones  (digit2)
  );

  assign interval = r_interval;
  assign note_cnt = r_note_cnt;

endmodule
`default_nettype wire

// File: tb/tb_learn_score_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_learn_score_keeper                                                |
// | Directed and randomized checks against a cycle-count reference model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_learn_score_keeper;

  localparam int TICK_DIV = 4;
  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_learn  = 2'd1;
  localparam logic [1:0] c_finish = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] learn_state = 2'd0;
  logic       note_valid = 1'b0;
  logic       note_correct = 1'b0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [2:0] interval;
  logic [5:0] note_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: score as an integer, elapsed learn cycles since last note.
  int         m_score;
  int         m_cnt;
  int         m_int;
  int         m_elapsed;
  logic [1:0] m_prev;

  learn_score_keeper #(.TICK_DIV(TICK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .learn_state  (learn_state),
    .note_valid   (note_valid),
    .note_correct (note_correct),
    .digit1       (digit1),
    .digit2       (digit2),
    .interval     (interval),
    .note_cnt     (note_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_cnt = 0; m_int = 0; m_elapsed = 0; m_prev = c_idle;
  endtask

  task automatic model_clear();
    m_score = 0; m_cnt = 0; m_int = 0; m_elapsed = 0;
  endtask

  task automatic model_edge(input logic [1:0] ls, input logic nv, input logic nc);
    int t;
    if (ls == c_learn) begin
      if (m_prev != c_learn) begin
        model_clear();
      end else begin
        m_elapsed++;
        if (nv) begin
          t = m_elapsed / TICK_DIV;
          if (t > 15) t = 15;
          m_int = (t < 5) ? 1 : (t < 10) ? 2 : (t < 15) ? 3 : 4;
          if (m_cnt < 63) m_cnt++;
          if (nc && m_score < 99) m_score++;
          m_elapsed = 0;
        end
      end
    end else if (ls != c_finish) begin
      model_clear();
    end
    m_prev = ls;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".digit1"},   int'(digit1),   m_score / 10);
    check_eq({tag, ".digit2"},   int'(digit2),   m_score % 10);
    check_eq({tag, ".interval"}, int'(interval), m_int);
    check_eq({tag, ".note_cnt"}, int'(note_cnt), m_cnt);
  endtask

  // Drive one cycle, advance the model on the edge, compare just after it.
  task automatic step(input string tag, input logic [1:0] ls, input logic nv, input logic nc);
    learn_state  = ls;
    note_valid   = nv;
    note_correct = nc;
    @(posedge clk);
    model_edge(ls, nv, nc);
    #1;
    check_all(tag);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) step("learn_gap", c_learn, 1'b0, 1'b0);
  endtask

  task automatic new_session();
    step("to_idle", c_idle, 1'b0, 1'b0);
    step("entry", c_learn, 1'b0, 1'b0);
  endtask

  initial begin
    int gaps [4];
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // 12 notes, 7 correct, random spacing
    new_session();
    for (int i = 0; i < 12; i++) begin
      idle_gap($urandom_range(0, 3));
      step("score12", c_learn, 1'b1, (i < 7) ? 1'b1 : 1'b0);
    end
    check_eq("score12.tens", int'(digit1), 0);
    check_eq("score12.ones", int'(digit2), 7);
    check_eq("score12.cnt",  int'(note_cnt), 12);

    // grade boundaries
    gaps[0] = 19; gaps[1] = 20; gaps[2] = 40; gaps[3] = 80;
    new_session();
    step("grade_ref", c_learn, 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) begin
      idle_gap(gaps[g] - 1);
      step("grade", c_learn, 1'b1, 1'b0);
      check_eq("grade.exact", int'(interval), g + 1);
    end

    // saturation
    new_session();
    for (int i = 0; i < 105; i++) step("sat", c_learn, 1'b1, 1'b1);
    check_eq("sat.tens", int'(digit1), 9);
    check_eq("sat.ones", int'(digit2), 9);
    check_eq("sat.cnt",  int'(note_cnt), 63);

    // finish freezes, finish->learn clears and drops the entry-cycle note
    new_session();
    for (int i = 0; i < 34; i++) step("pre_fin", c_learn, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("finish", c_finish, 1'b1, 1'b1);
    check_eq("finish.tens", int'(digit1), 3);
    check_eq("finish.ones", int'(digit2), 4);
    step("reentry", c_learn, 1'b1, 1'b1);
    check_eq("reentry.score", int'({digit1, digit2}), 0);
    check_eq("reentry.cnt",   int'(note_cnt), 0);
    step("post_reentry", c_learn, 1'b1, 1'b1);

    // async reset mid-session
    new_session();
    for (int i = 0; i < 56; i++) step("pre_rst", c_learn, 1'b1, 1'b1);
    check_eq("pre_rst.tens", int'(digit1), 5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_entry", c_learn, 1'b1, 1'b1);
    check_eq("rst_entry.cnt", int'(note_cnt), 0);
    for (int i = 0; i < 5; i++) step("post_rst", c_learn, 1'b1, 1'b1);
    check_eq("post_rst.ones", int'(digit2), 5);

    // randomized traffic, mostly in learn
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] ls;
      r = $urandom_range(0, 99);
      ls = (r < 85) ? c_learn : (r < 93) ? c_finish : (r < 97) ? c_idle : 2'd3;
      step("rand", ls, ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
